inv_mix_columns_seq: RTL and testbench

- Sequencer for the AES decryption InvMixColumns step, sitting between the InvSubBytes/AddRoundKey stage and the round register of the decrypt core.
- Accepts a 128-bit state over a valid/ready handshake and registers it.
- Time-shares COLS_PER_CYCLE single-column GF(2^8) datapaths across the 4 state columns, then presents the 128-bit result on a valid/ready output.
- A bypass path serves the final decrypt round, which omits InvMixColumns.

---
 rtl/aes_pkg.sv | 15 +
 rtl/inv_mix_columns_seq_if.sv | 22 ++
 rtl/aes_gf_mul.sv | 52 +++++
 rtl/inv_mix_column.sv | 20 ++
 rtl/inv_mix_columns_seq.sv | 99 +++++++++
 tb/tb_inv_mix_columns_seq.sv | 284 ++++++++++++++++++++++++++++
 6 files changed

// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the decrypt datapath.
package aes_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef logic [31:0]  col_t;
  typedef logic [127:0] aes_state_t;

  localparam int NUM_COLS = 4;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_x2(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/inv_mix_columns_seq_if.sv
// Input/output handshake bundle for the InvMixColumns sequencer.
interface inv_mix_columns_seq_if;
  import aes_pkg::*;

  logic       in_valid;
  logic       in_ready;
  logic       in_bypass;
  aes_state_t in_data;
  logic       out_valid;
  logic       out_ready;
  aes_state_t out_data;

  modport master (
    output in_valid, in_data, in_bypass, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_bypass, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/aes_gf_mul.sv
// Constant GF(2^8) multipliers used by InvMixColumns (x9, x11, x13, x14).
module mul9
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);
  logic [7:0] x2, x4, x8;
  assign x2 = gf_x2(a);
  assign x4 = gf_x2(x2);
  assign x8 = gf_x2(x4);
  assign y  = x8 ^ a;
endmodule

module mul11
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);
  logic [7:0] x2, x4, x8;
  assign x2 = gf_x2(a);
  assign x4 = gf_x2(x2);
  assign x8 = gf_x2(x4);
  assign y  = x8 ^ x2 ^ a;
endmodule

module mul13
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);
  logic [7:0] x2, x4, x8;
  assign x2 = gf_x2(a);
  assign x4 = gf_x2(x2);
  assign x8 = gf_x2(x4);
  assign y  = x8 ^ x4 ^ a;
endmodule

module mul14
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);
  logic [7:0] x2, x4, x8;
  assign x2 = gf_x2(a);
  assign x4 = gf_x2(x2);
  assign x8 = gf_x2(x4);
  assign y  = x8 ^ x4 ^ x2;
endmodule

// File: rtl/inv_mix_column.sv
// Single-column InvMixColumns: b_r = 14a_r ^ 11a_{r+1} ^ 13a_{r+2} ^ 9a_{r+3}.
module inv_mix_column
  import aes_pkg::*;
(
  input  col_t col_in,
  output col_t col_out
);
  logic [3:0][7:0] a, m9, m11, m13, m14, b;

  // Row 0 is the most significant byte of the column word.
  for (genvar r = 0; r < 4; r++) begin : g_row
    assign a[r] = col_in[31-8*r -: 8];
    mul9  u_m9  (.a(a[r]), .y(m9[r]));
    mul11 u_m11 (.a(a[r]), .y(m11[r]));
    mul13 u_m13 (.a(a[r]), .y(m13[r]));
    mul14 u_m14 (.a(a[r]), .y(m14[r]));
    assign b[r] = m14[r] ^ m11[(r+1)%4] ^ m13[(r+2)%4] ^ m9[(r+3)%4];
    assign col_out[31-8*r -: 8] = b[r];
  end
endmodule

// File: rtl/inv_mix_columns_seq.sv
// InvMixColumns sequencer: registers a state, runs COLS_PER_CYCLE column
// datapaths over NUM_PASSES cycles, and holds the result until taken.
module inv_mix_columns_seq
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   clear,
  inv_mix_columns_seq_if.slave   bus,
  output logic                   busy
);
  localparam int NUM_PASSES = NUM_COLS / COLS_PER_CYCLE;
  localparam int CW         = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cfg
    $error("COLS_PER_CYCLE must be 1, 2 or 4");
  end

  state_t                           state, state_n;
  logic [CW-1:0]                    col_cnt;
  aes_state_t                       src_reg, res_reg, res_n, out_q;
  logic                             byp_reg;
  logic                             accept, last_pass;
  int                               col_base;
  logic [COLS_PER_CYCLE-1:0][31:0]  lane_in, lane_out;

  assign bus.in_ready  = (state == IDLE) | ((state == DONE) & bus.out_ready);
  assign bus.out_valid = (state == DONE);
  assign bus.out_data  = out_q;
  assign busy          = (state == BUSY);

  assign accept    = bus.in_valid & bus.in_ready;
  assign last_pass = (col_cnt == CW'(NUM_PASSES - 1));
  assign col_base  = int'(col_cnt) * COLS_PER_CYCLE;

  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_lane
    inv_mix_column u_col (.col_in(lane_in[k]), .col_out(lane_out[k]));
  end

  // Route this pass's source columns to the lanes.
  always_comb begin
    lane_in = '0;
    for (int k = 0; k < COLS_PER_CYCLE; k++)
      lane_in[k] = src_reg[127 - 32*(col_base + k) -: 32];
  end

  // Merge the lane results into the running result state.
  always_comb begin
    res_n = res_reg;
    for (int k = 0; k < COLS_PER_CYCLE; k++)
      res_n[127 - 32*(col_base + k) -: 32] = lane_out[k];
  end

  // Next-state logic; DONE with out_ready may accept the next block directly.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (accept) state_n = bus.in_bypass ? DONE : BUSY;
      BUSY: if (last_pass) state_n = DONE;
      DONE: if (bus.out_ready) state_n = accept ? (bus.in_bypass ? DONE : BUSY) : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State register; clear wins over everything at the edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)     state <= IDLE;
    else if (clear) state <= IDLE;
    else            state <= state_n;
  end

  // Datapath registers: capture on accept, accumulate columns in BUSY.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      col_cnt <= '0;
      src_reg <= '0;
      byp_reg <= 1'b0;
      res_reg <= '0;
      out_q   <= '0;
    end else if (clear) begin
      col_cnt <= '0;
      src_reg <= '0;
      byp_reg <= 1'b0;
      res_reg <= '0;
      out_q   <= '0;
    end else if (accept) begin
      src_reg <= bus.in_data;
      byp_reg <= bus.in_bypass;
      col_cnt <= '0;
      if (bus.in_bypass) out_q <= bus.in_data;
    end else if (state == BUSY && !byp_reg) begin
      res_reg <= res_n;
      col_cnt <= last_pass ? '0 : col_cnt + CW'(1);
      if (last_pass) out_q <= res_n;
    end
  end
endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Directed and random checks for the InvMixColumns sequencer.
module tb_inv_mix_columns_seq;
  localparam int CPC = 1;
  localparam int NP  = 4 / CPC;

  localparam logic [127:0] KV_IN  = 128'h8e4da1bc_046681e5_01010101_c6c6c6c6;
  localparam logic [127:0] KV_OUT = 128'hdb135345_d4bf5d30_01010101_c6c6c6c6;
  localparam logic [127:0] V2_IN  = 128'h9fdc589d_4d7ebdf8_d5d5d7d6_00000000;
  localparam logic [127:0] V2_OUT = 128'hf20a225c_2d26314c_d4d4d4d5_00000000;
  localparam logic [127:0] BY_IN  = 128'h00010203_04050607_08090a0b_0c0d0e0f;

  logic clk, n_rst, clear, busy;
  int   n_checks = 0;
  int   n_fail   = 0;

  inv_mix_columns_seq_if bus();

  inv_mix_columns_seq #(.COLS_PER_CYCLE(CPC)) dut (
    .clk(clk), .n_rst(n_rst), .clear(clear), .bus(bus), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s, input logic byp);
    logic [127:0] r;
    logic [7:0]   a [4];
    logic [7:0]   cf [4];
    logic [7:0]   acc;
    cf[0] = 8'd14; cf[1] = 8'd11; cf[2] = 8'd13; cf[3] = 8'd9;
    if (byp) return s;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) a[i] = s[127 - 32*c - 8*i -: 8];
      for (int i = 0; i < 4; i++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(a[(i+j)%4], cf[j]);
        r[127 - 32*c - 8*i -: 8] = acc;
      end
    end
    return r;
  endfunction

  // Offer one block, then count edges (accept edge = 1) until out_valid; -1 on timeout.
  task automatic send(input logic [127:0] d, input logic byp, output int lat);
    int w;
    @(negedge clk);
    w = 0;
    while (!bus.in_ready && w < 50) begin @(negedge clk); w++; end
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_bypass = byp;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.in_bypass = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin @(negedge clk); lat++; end
    if (!bus.out_valid) lat = -1;
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b1;
    #2 n_rst = 1'b0;
    #20;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    n_checks++; if (bus.out_data !== 128'h0) begin n_fail++; $display("FAIL reset_out_data got=%h want=0", bus.out_data); end
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic test_known_vectors();
    int lat;
    logic [127:0] vin [2];
    logic [127:0] vout [2];
    vin[0] = KV_IN; vout[0] = KV_OUT;
    vin[1] = V2_IN; vout[1] = V2_OUT;
    for (int v = 0; v < 2; v++) begin
      send(vin[v], 1'b0, lat);
      n_checks++; if (lat != NP + 1) begin n_fail++; $display("FAIL kv%0d_latency got=%0d want=%0d", v, lat, NP + 1); end
      n_checks++; if (bus.out_data !== vout[v]) begin n_fail++; $display("FAIL kv%0d_data got=%h want=%h", v, bus.out_data, vout[v]); end
      n_checks++; if (bus.in_ready !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL kv%0d_done_flags in_ready=%b busy=%b want 0,0", v, bus.in_ready, busy); end
      consume();
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL kv%0d_consumed got=%b want=0", v, bus.out_valid); end
    end
  endtask

  task automatic test_bypass();
    int lat;
    send(BY_IN, 1'b1, lat);
    n_checks++; if (lat != 1) begin n_fail++; $display("FAIL bypass_latency got=%0d want=1", lat); end
    n_checks++; if (bus.out_data !== BY_IN) begin n_fail++; $display("FAIL bypass_data got=%h want=%h", bus.out_data, BY_IN); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bypass_busy got=%b want=0", busy); end
    consume();
  endtask

  task automatic test_back_to_back();
    int lat;
    send(KV_IN, 1'b0, lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== KV_OUT || bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_cycle%0d valid=%b data=%h in_ready=%b want 1,%h,0", i, bus.out_valid, bus.out_data, bus.in_ready, KV_OUT);
      end
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = V2_IN;
    bus.in_bypass = 1'b0;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready got=%b want=1", bus.in_ready); end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL b2b_state out_valid=%b busy=%b want 0,1", bus.out_valid, busy); end
    lat = 1;
    while (!bus.out_valid && lat < 40) begin @(negedge clk); lat++; end
    n_checks++; if (lat != NP + 1) begin n_fail++; $display("FAIL b2b_latency got=%0d want=%0d", lat, NP + 1); end
    n_checks++; if (bus.out_data !== V2_OUT) begin n_fail++; $display("FAIL b2b_data got=%h want=%h", bus.out_data, V2_OUT); end
    consume();
  endtask

  task automatic test_reset_busy();
    int lat;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = KV_IN;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #2 n_rst = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_data !== 128'h0) begin
      n_fail++;
      $display("FAIL async_reset valid=%b busy=%b in_ready=%b data=%h want 0,0,1,0", bus.out_valid, busy, bus.in_ready, bus.out_data);
    end
    @(negedge clk);
    n_rst = 1'b1;
    send(V2_IN, 1'b0, lat);
    n_checks++; if (lat != NP + 1 || bus.out_data !== V2_OUT) begin n_fail++; $display("FAIL after_reset lat=%0d data=%h want %0d,%h", lat, bus.out_data, NP + 1, V2_OUT); end
    consume();
  endtask

  task automatic test_clear();
    int   lat;
    logic ov_seen;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = KV_IN;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat ((NP > 2) ? 2 : 0) @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL clear_pre_busy got=%b want=1", busy); end
    clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_idle busy=%b in_ready=%b out_valid=%b want 0,1,0", busy, bus.in_ready, bus.out_valid);
    end
    ov_seen = 1'b0;
    repeat (8) begin @(negedge clk); if (bus.out_valid) ov_seen = 1'b1; end
    n_checks++; if (ov_seen !== 1'b0) begin n_fail++; $display("FAIL clear_no_valid got=%b want=0", ov_seen); end
    send(KV_IN, 1'b0, lat);
    n_checks++; if (lat != NP + 1 || bus.out_data !== KV_OUT) begin n_fail++; $display("FAIL after_clear lat=%0d data=%h want %0d,%h", lat, bus.out_data, NP + 1, KV_OUT); end
    consume();
  endtask

  task automatic test_isolation();
    int lat;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_data   = V2_IN;
    bus.in_bypass = 1'b0;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    while (!bus.out_valid && lat < 40) begin
      bus.in_data   = {$urandom, $urandom, $urandom, $urandom};
      bus.in_bypass = 1'($urandom_range(1));
      @(negedge clk);
      lat++;
    end
    bus.in_bypass = 1'b0;
    n_checks++; if (lat != NP + 1) begin n_fail++; $display("FAIL iso_latency got=%0d want=%0d", lat, NP + 1); end
    n_checks++; if (bus.out_data !== V2_OUT) begin n_fail++; $display("FAIL iso_data got=%h want=%h", bus.out_data, V2_OUT); end
    consume();
  endtask

  task automatic test_random();
    logic [127:0] q [$];
    logic [127:0] d, exp;
    logic         b;
    int           blocks = 0;
    int           cyc = 0;
    while (blocks < 1000 && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      d = {$urandom, $urandom, $urandom, $urandom};
      b = ($urandom_range(3) == 0);
      bus.out_ready = ($urandom_range(3) != 0);
      bus.in_valid  = ($urandom_range(3) != 0);
      bus.in_data   = d;
      bus.in_bypass = b;
      #1;
      if (bus.out_valid && bus.out_ready) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL rand_spurious_out data=%h", bus.out_data);
        end else begin
          exp = q.pop_front();
          if (bus.out_data !== exp) begin n_fail++; $display("FAIL rand_data got=%h want=%h", bus.out_data, exp); end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(model(d, b));
        blocks++;
      end
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) begin
      #1;
      if (bus.out_valid) begin
        exp = q.pop_front();
        n_checks++; if (bus.out_data !== exp) begin n_fail++; $display("FAIL rand_drain got=%h want=%h", bus.out_data, exp); end
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    n_checks++; if (blocks != 1000 || q.size() != 0) begin n_fail++; $display("FAIL rand_progress blocks=%0d pending=%0d want 1000,0", blocks, q.size()); end
  endtask

  initial begin
    clear         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_bypass = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_known_vectors();
    test_bypass();
    test_back_to_back();
    test_reset_busy();
    test_clear();
    test_isolation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
